gen_seq_ctrl: RTL
=================

# gen_seq_ctrl

Sequencing controller for the sequence-generator cluster (overlapping/non-overlapping, Moore/Mealy generator outputs). On a start request it restarts the generators from their reset state, selects one of the four generator output bits, and streams exactly `len` bits to a single serial output while counting the ones. It reports completion with a one-cycle `done` pulse and an `aborted` flag. It sits beside the generator top level, drives the generators' restart line, and consumes their four output bits.

## Interface
- `LEN_W`, 8: width of the length request and the ones counter.
- `NSRC`, 4: number of generator output bits; fixed at 4, so `src_sel` is 2 bits.

- `clk`  in  1  clock; all state updates on the rising edge.
- `nres`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `src_sel`  in  2  source select, latched on an accepted start. 0 = Moore non-overlap, 1 = Mealy non-overlap, 2 = Moore overlap, 3 = Mealy overlap.
- `len`  in  LEN_W  number of bits to stream, latched on an accepted start.
- `abort`  in  1  terminates an active run.
- `gen_bits`  in  4  generator outputs, indexed as in `src_sel`.
- `gen_nres`  out  1  generator restart, active-low; the top level ANDs it with `nres`.
- `sout`  out  1  selected generator bit.
- `svalid`  out  1  `sout` is a counted stream bit.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  last run ended by `abort`; held until the next accepted start.
- `ones_cnt`  out  LEN_W  ones streamed in the current or last run; held until the next accepted start.

## Operation
- States: IDLE, PRIME, RUN, DONE.
- **IDLE**
  - `start`=1 and `len`≠0: latch `sel_q`←`src_sel` and `rem`←`len`; clear `ones_cnt` and `aborted`; go to PRIME.
  - `start`=1 and `len`=0: clear `ones_cnt` and `aborted`; go directly to DONE with no stream bits.
- **PRIME**
  - Lasts exactly one cycle; `gen_nres`=0 (registered output).
  - Next state is RUN.
  - `abort`=1 goes to DONE instead, with `aborted`←1.
- **RUN**
  - `gen_nres`=1, `svalid`=1, `sout`=`gen_bits[sel_q]` (combinational pass-through).
  - Each cycle: `ones_cnt` += `sout`; `rem` −= 1.
  - When `rem`=1, go to DONE after this bit.
- **abort in RUN**
  - The current bit is not counted; `svalid` is still 1 on that cycle.
  - `aborted`←1; go to DONE.
  - `abort` takes priority over the last-bit transition.
- **DONE**
  - `done`=1 for one cycle; return to IDLE.
- Common rules:
  - `start` outside IDLE is ignored; it is neither queued nor latched.
  - `abort` in IDLE or DONE is ignored.
  - `src_sel` and `len` changes during a run have no effect.
- Widths:
  - `rem` is LEN_W bits and never wraps; the maximum run is 2^LEN_W−1 bits.
  - `ones_cnt` ≤ `len`, so it never overflows.

## Timing
- **Reset values:** state=IDLE, `gen_nres`=1, `sout`=0, `svalid`=0, `busy`=0, `done`=0, `aborted`=0, `ones_cnt`=0, `sel_q`=0, `rem`=0.
- **Accepted start at edge E0:** PRIME covers E0–E1 (`gen_nres` low); RUN begins at E1.
- **Run of length `len`:** RUN lasts `len` cycles; `done` is high during cycle `len`+1 after E0; IDLE resumes after `len`+2 cycles.
- **`len`=0:** `done` is high in the cycle after E0.
- **Outputs outside RUN:** `sout`=0 and `svalid`=0.
- **`busy`:** combinational from state; high in PRIME, RUN and DONE.
- **Back-to-back requests:** the earliest next start is the cycle after DONE (IDLE). There is no start acceptance in DONE.
- **Reset mid-run:** all outputs return to reset values asynchronously. There is no `done` pulse, and `ones_cnt` is lost.

## Structure
- Package `gen_ctrl_pkg`:
  - `ctrl_state_t` enum {IDLE, PRIME, RUN, DONE}.
  - `NSRC`=4.
  - Source-index localparams `SRC_MOORE_NP`, `SRC_MEALY_NP`, `SRC_MOORE_P`, `SRC_MEALY_P`.
- Sub-module `gen_bit_cnt`:
  - Loadable down-counter for `rem` plus the ones accumulator, with load/enable/bit inputs, parameterised by LEN_W.
  - The FSM and the source mux stay in `gen_seq_ctrl`.

## Test plan
- Reset, then idle: all outputs at reset values; `start`=0 for 10 cycles → state stays IDLE, `gen_nres`=1.
- `start`, `src_sel`=2, `len`=5, `gen_bits`=4'b0100 constant:
  - `gen_nres` low for 1 cycle.
  - `svalid` high for exactly 5 cycles with `sout`=1.
  - `done` pulses on cycle 6; `ones_cnt`=5, `aborted`=0.
- `start`, `len`=0 → `done` in the next cycle, `svalid` never asserted, `ones_cnt`=0.
- `len`=8, `abort` on the 3rd RUN cycle with `gen_bits` all ones:
  - `ones_cnt`=2, `aborted`=1.
  - `done` in the following cycle.
- `start` held high during a `len`=4 run, with `src_sel` toggled mid-run:
  - Only one run occurs; `sout` follows the latched select.
  - A new run is accepted on the first IDLE cycle after `done`.
- `nres` asserted mid-RUN (`len`=6, after 3 bits) → outputs reset immediately; no `done`; `ones_cnt`=0.

Source files
------------

// File: rtl/gen_ctrl_pkg.sv
// gen_ctrl_pkg: shared types and constants for the sequence-generator controller
package gen_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;
    localparam int NSRC = 4;
    localparam logic [1:0] SRC_MOORE_NP = 2'd0;
    localparam logic [1:0] SRC_MEALY_NP = 2'd1;
    localparam logic [1:0] SRC_MOORE_P  = 2'd2;
    localparam logic [1:0] SRC_MEALY_P  = 2'd3;
endpackage

// File: rtl/gen_bit_cnt.sv
// gen_bit_cnt: loadable remaining-bit down-counter plus ones accumulator
// Ports: clk, nres (async active-low); load copies len into rem and clears ones;
//        en decrements rem and adds din to ones; rem/ones are the live counts.
module gen_bit_cnt #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             nres,
    input  logic             load,
    input  logic             en,
    input  logic             din,
    input  logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] rem,
    output logic [LEN_W-1:0] ones
);
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            rem  <= '0;
            ones <= '0;
        end else if (load) begin
            rem  <= len;
            ones <= '0;
        end else if (en) begin
            rem  <= rem - 1'b1;
            ones <= ones + {{(LEN_W-1){1'b0}}, din};
        end
    end
endmodule

// File: rtl/gen_seq_ctrl.sv
// gen_seq_ctrl: restarts the generators, then streams len bits of one selected source
// Ports: clk, nres (async active-low); start/src_sel/len request a run, abort ends it;
//        gen_bits are the generator outputs, gen_nres restarts them (low in PRIME);
//        sout/svalid carry the stream, busy/done/aborted/ones_cnt report status.
module gen_seq_ctrl
    import gen_ctrl_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             nres,
    input  logic             start,
    input  logic [1:0]       src_sel,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic [NSRC-1:0]  gen_bits,
    output logic             gen_nres,
    output logic             sout,
    output logic             svalid,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [LEN_W-1:0] ones_cnt
);
    ctrl_state_t      state, nxt;
    logic [1:0]       sel_q;
    logic [LEN_W-1:0] rem;
    logic             go;

    assign go     = (state == IDLE) && start;
    assign svalid = (state == RUN);
    assign sout   = svalid & gen_bits[sel_q];
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    // abort wins over the last-bit exit in RUN
    always_comb begin
        nxt = state == IDLE  ? (start ? (len != '0 ? PRIME : DONE) : IDLE) :
              state == PRIME ? (abort ? DONE : RUN) :
              state == RUN   ? ((abort || rem == LEN_W'(1)) ? DONE : RUN) :
                               IDLE;
    end

    // gen_nres is registered from the next state so it is glitch-free and low exactly in PRIME
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state    <= IDLE;
            gen_nres <= 1'b1;
            sel_q    <= '0;
            aborted  <= 1'b0;
        end else begin
            state    <= nxt;
            gen_nres <= (nxt != PRIME);
            if (go && len != '0) sel_q <= src_sel;
            aborted  <= go ? 1'b0 : (abort && (state == PRIME || state == RUN)) ? 1'b1 : aborted;
        end
    end

    // the bit on an abort cycle is shown but not counted
    gen_bit_cnt #(.LEN_W(LEN_W)) u_cnt (
        .clk  (clk),
        .nres (nres),
        .load (go),
        .en   (svalid && !abort),
        .din  (sout),
        .len  (len),
        .rem  (rem),
        .ones (ones_cnt)
    );
endmodule
